// File: rtl/cnn_window_feeder.sv
// cnn_window_feeder: collects one IMG_W x IMG_W pixel frame into an internal
// buffer, then streams every K x K window (START pulse, X/Y/IMGIN per cycle)
// to the simpleCNN core and latches its class result when DONE comes back.
// Optional build macro: FEEDER_FRAME_CNT_EN adds the FRAME_CNT output, a
// 16-bit wrapping count of completed classifications.
module cnn_window_feeder #(
  parameter int IMG_W = 28,
  parameter int K     = 5,
  parameter int PIX_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   PIX_VALID,
  input  logic [PIX_W-1:0]       PIX_DATA,
  output logic                   PIX_READY,
  output logic                   START,
  output logic [4:0]             X,
  output logic [4:0]             Y,
  output logic [K*K*PIX_W-1:0]   IMGIN,
  input  logic                   CNN_DONE,
  input  logic [3:0]             CNN_OUT,
  output logic                   RESULT_VALID,
  output logic [3:0]             RESULT,
  output logic                   BUSY
`ifdef FEEDER_FRAME_CNT_EN
  ,
  output logic [15:0]            FRAME_CNT
`endif
);

  localparam int       OW       = IMG_W - K + 1;
  localparam int       NPIX     = IMG_W * IMG_W;
  localparam [4:0]     LAST_POS = 5'(OW - 1);
  localparam [4:0]     LAST_COL = 5'(IMG_W - 1);
  localparam [9:0]     LAST_CNT = 10'(NPIX - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_KICK   = 2'd1,
    S_STREAM = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t                r_state;
  logic [9:0]            r_cnt;
  logic [4:0]            r_row;
  logic [4:0]            r_col;
  logic [PIX_W-1:0]      r_buf [0:IMG_W-1][0:IMG_W-1];

  logic                  w_accept;
  logic                  w_end;
  logic [4:0]            w_rd_x;
  logic [4:0]            w_rd_y;
  logic [K*K*PIX_W-1:0]  w_win;

  assign w_accept = (r_state == S_LOAD) && PIX_VALID;
  assign w_end    = (X == LAST_POS) && (Y == LAST_POS);

  // Select which window the next registered IMGIN should hold.
  always_comb begin
    w_rd_x = X;
    w_rd_y = Y;
    case (r_state)
      S_LOAD: begin
        w_rd_x = 5'd0;
        w_rd_y = 5'd0;
      end
      S_STREAM: begin
        if (w_end) begin
          w_rd_x = X;
          w_rd_y = Y;
        end else if (Y == LAST_POS) begin
          w_rd_x = X + 5'd1;
          w_rd_y = 5'd0;
        end else begin
          w_rd_x = X;
          w_rd_y = Y + 5'd1;
        end
      end
      default: begin
        w_rd_x = X;
        w_rd_y = Y;
      end
    endcase
  end

  // Gather the K x K window at (w_rd_x, w_rd_y); element (i,j) at byte i*K+j.
  always_comb begin
    w_win = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        w_win[(i*K+j)*PIX_W +: PIX_W] = r_buf[w_rd_x + 5'(i)][w_rd_y + 5'(j)];
      end
    end
  end

  // Frame buffer write port; only live while loading, contents need no reset.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_buf[r_row][r_col] <= PIX_DATA;
    end
  end

  // Control FSM with all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_LOAD;
      r_cnt        <= 10'd0;
      r_row        <= 5'd0;
      r_col        <= 5'd0;
      START        <= 1'b0;
      X            <= 5'd0;
      Y            <= 5'd0;
      IMGIN        <= '0;
      RESULT       <= 4'd0;
      RESULT_VALID <= 1'b0;
      PIX_READY    <= 1'b1;
      BUSY         <= 1'b0;
`ifdef FEEDER_FRAME_CNT_EN
      FRAME_CNT    <= 16'd0;
`endif
    end else begin
      START        <= 1'b0;
      RESULT_VALID <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (PIX_VALID) begin
            r_cnt <= r_cnt + 10'd1;
            if (r_col == LAST_COL) begin
              r_col <= 5'd0;
              r_row <= r_row + 5'd1;
            end else begin
              r_col <= r_col + 5'd1;
            end
            if (r_cnt == LAST_CNT) begin
              // Last pixel: window (0,0) only needs rows already written.
              r_state   <= S_KICK;
              START     <= 1'b1;
              X         <= 5'd0;
              Y         <= 5'd0;
              IMGIN     <= w_win;
              PIX_READY <= 1'b0;
              BUSY      <= 1'b1;
            end
          end
        end
        S_KICK: begin
          // Window (0,0) is presented again on the first streaming cycle.
          r_state <= S_STREAM;
          IMGIN   <= w_win;
        end
        S_STREAM: begin
          X     <= w_rd_x;
          Y     <= w_rd_y;
          IMGIN <= w_win;
          if (w_end) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (CNN_DONE) begin
            RESULT       <= CNN_OUT;
            RESULT_VALID <= 1'b1;
            r_cnt        <= 10'd0;
            r_row        <= 5'd0;
            r_col        <= 5'd0;
            r_state      <= S_LOAD;
            PIX_READY    <= 1'b1;
            BUSY         <= 1'b0;
`ifdef FEEDER_FRAME_CNT_EN
            FRAME_CNT    <= FRAME_CNT + 16'd1;
`endif
          end
        end
        default: begin
          r_state   <= S_LOAD;
          PIX_READY <= 1'b1;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_window_feeder.sv
// Directed self-checking bench for cnn_window_feeder.
module tb_cnn_window_feeder;

  logic         CLK = 1'b0;
  logic         RST;
  logic         PIX_VALID;
  logic [7:0]   PIX_DATA;
  logic         PIX_READY;
  logic         START;
  logic [4:0]   X;
  logic [4:0]   Y;
  logic [199:0] IMGIN;
  logic         CNN_DONE;
  logic [3:0]   CNN_OUT;
  logic         RESULT_VALID;
  logic [3:0]   RESULT;
  logic         BUSY;
`ifdef FEEDER_FRAME_CNT_EN
  logic [15:0]  FRAME_CNT;
`endif

  int checks   = 0;
  int failures = 0;

  cnn_window_feeder dut (
    .CLK(CLK), .RST(RST), .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA),
    .PIX_READY(PIX_READY), .START(START), .X(X), .Y(Y), .IMGIN(IMGIN),
    .CNN_DONE(CNN_DONE), .CNN_OUT(CNN_OUT), .RESULT_VALID(RESULT_VALID),
    .RESULT(RESULT), .BUSY(BUSY)
`ifdef FEEDER_FRAME_CNT_EN
    , .FRAME_CNT(FRAME_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int pat, input int r, input int c);
    if (pat == 0) return 8'((r*28 + c) % 256);
    else          return 8'((r*7 + c*13 + 5) % 256);
  endfunction

  function automatic logic [199:0] exp_win(input int pat, input int x, input int y);
    logic [199:0] w;
    w = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        w[(i*5+j)*8 +: 8] = pix_val(pat, x+i, y+j);
    return w;
  endfunction

  // Drive one raster frame; returns at the negedge of the KICK cycle.
  task automatic load_frame(input int pat, input logic hold_valid);
    for (int idx = 0; idx < 784; idx++) begin
      @(negedge CLK);
      if (idx == 0) chk("load_ready", 200'(PIX_READY), 200'd1);
      PIX_VALID = 1'b1;
      PIX_DATA  = pix_val(pat, idx/28, idx%28);
    end
    @(negedge CLK);
    PIX_VALID = hold_valid;
    PIX_DATA  = 8'hFF;
  endtask

  // Walk cycles t=1 (KICK) .. 590 (WAIT); optionally abort at abort_t.
  task automatic run_stream(input int pat, input int abort_t,
                            input logic [3:0] done_out, input logic [3:0] prev_res);
    int bad_win, bad_pos, bad_start, bad_stat, k, ex, ey, last_t;
    logic [199:0] ew;
    bad_win = 0; bad_pos = 0; bad_start = 0; bad_stat = 0; last_t = 590;
    for (int t = 1; t <= 590; t++) begin
      k  = (t < 2) ? 0 : ((t - 2 > 575) ? 575 : t - 2);
      ex = k / 24;
      ey = k % 24;
      ew = exp_win(pat, ex, ey);
      if (IMGIN !== ew) bad_win++;
      if (X !== 5'(ex) || Y !== 5'(ey)) bad_pos++;
      if (START !== (t == 1)) bad_start++;
      if (BUSY !== 1'b1 || PIX_READY !== 1'b0) bad_stat++;
      if (t == 1) begin
        chk("kick_start", 200'(START), 200'd1);
        chk("kick_xy", 200'({X, Y}), 200'd0);
        chk("kick_b0", 200'(IMGIN[7:0]), 200'(pix_val(pat, 0, 0)));
        chk("kick_b4", 200'(IMGIN[39:32]), 200'(pix_val(pat, 0, 4)));
        chk("kick_b5", 200'(IMGIN[47:40]), 200'(pix_val(pat, 1, 0)));
        chk("kick_b24", 200'(IMGIN[199:192]), 200'(pix_val(pat, 4, 4)));
      end
      if (t == 3 && pat == 0) begin
        chk("n3_xy", 200'({X, Y}), 200'({5'd0, 5'd1}));
        chk("n3_b0", 200'(IMGIN[7:0]), 200'd1);
      end
      if (t == 26 && pat == 0) begin
        chk("n26_xy", 200'({X, Y}), 200'({5'd1, 5'd0}));
        chk("n26_b0", 200'(IMGIN[7:0]), 200'd28);
      end
      if ((t == 577 || t == 590) && pat == 0) begin
        chk("end_xy", 200'({X, Y}), 200'({5'd23, 5'd23}));
        chk("end_b0", 200'(IMGIN[7:0]), 200'd155);
        chk("end_b24", 200'(IMGIN[199:192]), 200'd15);
      end
      if (t == 100) begin
        CNN_DONE = 1'b1;
        CNN_OUT  = 4'd3;
      end
      if (t == 101) begin
        CNN_DONE = 1'b0;
        chk("stream_done_rv", 200'(RESULT_VALID), 200'd0);
        chk("stream_done_res", 200'(RESULT), 200'(prev_res));
      end
      if (t == abort_t) begin
        last_t = t;
        break;
      end
      if (t < 590) @(negedge CLK);
    end
    chk("all_windows", 200'(bad_win), 200'd0);
    chk("all_positions", 200'(bad_pos), 200'd0);
    chk("start_once", 200'(bad_start), 200'd0);
    chk("busy_ready", 200'(bad_stat), 200'd0);
    if (last_t == 590) begin
      CNN_DONE  = 1'b1;
      CNN_OUT   = done_out;
      PIX_VALID = 1'b0;
      @(negedge CLK);
      CNN_DONE = 1'b0;
      chk("done_result", 200'(RESULT), 200'(done_out));
      chk("done_rv", 200'(RESULT_VALID), 200'd1);
      chk("done_ready", 200'(PIX_READY), 200'd1);
      chk("done_busy", 200'(BUSY), 200'd0);
      @(negedge CLK);
      chk("rv_one_cycle", 200'(RESULT_VALID), 200'd0);
      chk("result_held", 200'(RESULT), 200'(done_out));
    end
  endtask

  initial begin
    RST = 1'b1; PIX_VALID = 1'b0; PIX_DATA = 8'd0; CNN_DONE = 1'b0; CNN_OUT = 4'd0;
    repeat (2) @(negedge CLK);
    chk("rst_outputs", 200'({START, X, Y, RESULT, RESULT_VALID, BUSY}), 200'd0);
    chk("rst_imgin", IMGIN, 200'd0);
    chk("rst_ready", 200'(PIX_READY), 200'd1);
`ifdef FEEDER_FRAME_CNT_EN
    chk("rst_fcnt", 200'(FRAME_CNT), 200'd0);
`endif
    RST = 1'b0;

    // DONE while loading must be ignored.
    CNN_DONE = 1'b1; CNN_OUT = 4'd9;
    @(negedge CLK);
    CNN_DONE = 1'b0;
    chk("load_done_rv", 200'(RESULT_VALID), 200'd0);
    chk("load_done_res", 200'(RESULT), 200'd0);

    // Frame 1 with PIX_VALID held high through STREAM/WAIT.
    load_frame(0, 1'b1);
    run_stream(0, 0, 4'd7, 4'd0);
`ifdef FEEDER_FRAME_CNT_EN
    chk("fcnt_1", 200'(FRAME_CNT), 200'd1);
`endif

    // Identical second frame must give identical windows.
    load_frame(0, 1'b0);
    run_stream(0, 0, 4'd12, 4'd7);
`ifdef FEEDER_FRAME_CNT_EN
    chk("fcnt_2", 200'(FRAME_CNT), 200'd2);
`endif

    // Abort at window (10,5): t = 2 + 10*24 + 5.
    load_frame(0, 1'b1);
    run_stream(0, 247, 4'd0, 4'd12);
    chk("abort_xy", 200'({X, Y}), 200'({5'd10, 5'd5}));
    RST = 1'b1; PIX_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_start", 200'(START), 200'd0);
    chk("abort_xy0", 200'({X, Y}), 200'd0);
    chk("abort_imgin", IMGIN, 200'd0);
    chk("abort_ready", 200'(PIX_READY), 200'd1);
    chk("abort_busy", 200'(BUSY), 200'd0);
    CNN_DONE = 1'b1; CNN_OUT = 4'd11;
    @(negedge CLK);
    CNN_DONE = 1'b0;
    chk("abort_done_rv", 200'(RESULT_VALID), 200'd0);
    chk("abort_done_res", 200'(RESULT), 200'd0);

    // Fresh frame with a different pattern after the abort.
    load_frame(1, 1'b0);
    run_stream(1, 0, 4'd5, 4'd0);
`ifdef FEEDER_FRAME_CNT_EN
    chk("fcnt_after_abort", 200'(FRAME_CNT), 200'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
